// File: rtl/mpmc10_fifo_sched_if.sv
// Bundle between the mpmc10 FIFO read scheduler and its surroundings.
// master = scheduler side, slave = FIFO bank and memory-side state machine.
interface mpmc10_fifo_sched_if #(
  parameter int NCH = 4,
  parameter int DW  = 128
) ();
  localparam int CHW = $clog2(NCH);

  logic [NCH-1:0]    empty;
  logic [NCH-1:0]    rd_rst_busy;
  logic [NCH-1:0]    fifo_v;
  logic [NCH*DW-1:0] fifo_dat;
  logic [NCH-1:0]    rd_fifo;
  logic [DW-1:0]     req_o;
  logic              req_v;
  logic              req_rdy;
  logic [CHW-1:0]    req_ch;
  logic              busy;
  logic              err;

  modport master (
    input  empty, rd_rst_busy, fifo_v, fifo_dat, req_rdy,
    output rd_fifo, req_o, req_v, req_ch, busy, err
  );

  modport slave (
    output empty, rd_rst_busy, fifo_v, fifo_dat, req_rdy,
    input  rd_fifo, req_o, req_v, req_ch, busy, err
  );
endinterface

// File: rtl/mpmc10_fifo_sched.sv
// Round-robin burst-limited read scheduler for the mpmc10 per-channel request FIFOs.
// Pops one word at a time, captures it, and holds it on a valid/ready handshake.
module mpmc10_fifo_sched #(
  parameter int NCH   = 4,
  parameter int DW    = 128,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mpmc10_fifo_sched_if.master  bus
);
  localparam int CHW = $clog2(NCH);

  typedef enum logic [1:0] {IDLE, READ, WAIT, OUT} state_t;

  state_t         state;
  logic [CHW-1:0] ptr;
  logic [CHW-1:0] gnt;
  logic [3:0]     burst_cnt;
  logic [NCH-1:0] rd_q;
  logic [DW-1:0]  req_q;
  logic [CHW-1:0] ch_q;
  logic           err_q;

  logic [NCH-1:0] elig;
  logic           found;
  logic [CHW-1:0] pick;
  logic [CHW-1:0] idx;
  logic           sel_v;
  logic [DW-1:0]  sel_dat;
  logic [CHW-1:0] ptr_nxt;
  logic [4:0]     cnt_nxt;

  assign elig    = ~bus.empty & ~bus.rd_rst_busy;
  assign ptr_nxt = (gnt == CHW'(NCH - 1)) ? '0 : gnt + 1'b1;
  assign cnt_nxt = {1'b0, burst_cnt} + 5'd1;

  // Descending scan so the candidate closest to ptr is the last one written.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = CHW'((int'(ptr) + k) % NCH);
      if (elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    sel_v   = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt == CHW'(i)) begin
        sel_v   = bus.fifo_v[i];
        sel_dat = bus.fifo_dat[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      burst_cnt <= '0;
      rd_q      <= '0;
      req_q     <= '0;
      ch_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      rd_q <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt       <= pick;
            burst_cnt <= '0;
            rd_q      <= {{(NCH-1){1'b0}}, 1'b1} << pick;
            state     <= READ;
          end
        end
        READ: begin
          state <= elig[gnt] ? WAIT : IDLE;
        end
        WAIT: begin
          if (sel_v) begin
            req_q <= sel_dat;
            ch_q  <= gnt;
            state <= OUT;
          end else begin
            err_q <= 1'b1;
            ptr   <= ptr_nxt;
            state <= IDLE;
          end
        end
        OUT: begin
          if (bus.req_rdy) begin
            burst_cnt <= cnt_nxt[3:0];
            if ((cnt_nxt < 5'(BURST)) && elig[gnt]) begin
              rd_q  <= {{(NCH-1){1'b0}}, 1'b1} << gnt;
              state <= READ;
            end else begin
              ptr   <= ptr_nxt;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The strobe is masked by live eligibility so a FIFO that empties or enters
  // read-reset during READ is never popped.
  assign bus.rd_fifo = rd_q & elig;
  assign bus.req_o   = req_q;
  assign bus.req_v   = (state == OUT);
  assign bus.req_ch  = ch_q;
  assign bus.busy    = (state != IDLE);
  assign bus.err     = err_q;
endmodule

// File: tb/tb_mpmc10_fifo_sched.sv
// Self-checking bench for mpmc10_fifo_sched: FIFO bank model, handshake monitor
// and a queue-based round-robin reference for the expected grant sequence.
module tb_mpmc10_fifo_sched;
  localparam int NCH   = 4;
  localparam int DW    = 32;
  localparam int BURST = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mpmc10_fifo_sched_if #(.NCH(NCH), .DW(DW)) bus ();

  mpmc10_fifo_sched #(.NCH(NCH), .DW(DW), .BURST(BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] fq [NCH][$];
  logic [DW-1:0] mq [NCH][$];
  int            expCh[$];
  logic [DW-1:0] expDat[$];
  int            gotCh[$];
  logic [DW-1:0] gotDat[$];
  bit            rdyRandom = 1'b0;
  bit            dropValid = 1'b0;
  logic [NCH-1:0] popMask;
  int            checks = 0;
  int            passes = 0;
  int            fails  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Standard-mode FIFO: data and data_valid appear the cycle after the read strobe.
  always @(posedge clk) begin
    popMask = bus.rd_fifo;
    #1;
    bus.fifo_v = '0;
    for (int i = 0; i < NCH; i++) begin
      if (popMask[i] && fq[i].size() > 0) begin
        bus.fifo_dat[i*DW +: DW] = fq[i].pop_front();
        bus.fifo_v[i] = !dropValid;
      end
      bus.empty[i] = (fq[i].size() == 0);
    end
    if (rdyRandom) bus.req_rdy = ($urandom_range(0, 3) != 0);
  end

  always @(posedge clk) begin
    if (rst_n && bus.req_v && bus.req_rdy) begin
      gotCh.push_back(int'(bus.req_ch));
      gotDat.push_back(bus.req_o);
    end
    if (bus.rd_fifo != '0) begin
      checkOutput("rd_onehot", 64'($countones(bus.rd_fifo)), 64'd1);
      checkOutput("rd_eligible", 64'(bus.rd_fifo & (bus.empty | bus.rd_rst_busy)), 64'd0);
    end
  end

  task automatic applyStimulus(input int ch, input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) fq[ch].push_back(base + DW'(k));
    if (n > 0) bus.empty[ch] = 1'b0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NCH; i++) fq[i].delete();
    bus.empty       = '1;
    bus.fifo_v      = '0;
    bus.rd_rst_busy = '0;
    repeat (2) @(negedge clk);
    gotCh.delete();
    gotDat.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Round-robin from startPtr: up to BURST words per visit, release early on empty.
  task automatic buildExpected(input int startPtr, input logic [NCH-1:0] mask);
    int p;
    int c;
    p = startPtr;
    for (int i = 0; i < NCH; i++) mq[i] = fq[i];
    expCh.delete();
    expDat.delete();
    while (1) begin
      c = -1;
      for (int k = 0; k < NCH; k++)
        if (c < 0 && !mask[(p + k) % NCH] && mq[(p + k) % NCH].size() > 0) c = (p + k) % NCH;
      if (c < 0) break;
      for (int b = 0; b < BURST && mq[c].size() > 0; b++) begin
        expCh.push_back(c);
        expDat.push_back(mq[c].pop_front());
      end
      p = (c + 1) % NCH;
    end
  endtask

  task automatic collectAndCompare(input string tag, input int budget);
    int n;
    int cyc;
    n   = expCh.size();
    cyc = 0;
    while (gotCh.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    repeat (6) @(negedge clk);
    checkOutput({tag, "_count"}, 64'(gotCh.size()), 64'(n));
    for (int i = 0; i < n && i < gotCh.size(); i++) begin
      checkOutput({tag, "_ch"}, 64'(gotCh[i]), 64'(expCh[i]));
      checkOutput({tag, "_dat"}, 64'(gotDat[i]), 64'(expDat[i]));
    end
    checkOutput({tag, "_idle"}, 64'(bus.busy), 64'd0);
    gotCh.delete();
    gotDat.delete();
  endtask

  initial begin
    logic [DW-1:0] v;
    bus.empty       = '1;
    bus.rd_rst_busy = '0;
    bus.fifo_v      = '0;
    bus.fifo_dat    = '0;
    bus.req_rdy     = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_rd_fifo", 64'(bus.rd_fifo), 64'd0);
    checkOutput("rst_req_v", 64'(bus.req_v), 64'd0);
    checkOutput("rst_req_o", 64'(bus.req_o), 64'd0);
    checkOutput("rst_req_ch", 64'(bus.req_ch), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_err", 64'(bus.err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single channel latency");
    bus.req_rdy = 1'b1;
    applyStimulus(2, 1, 32'hA5);
    @(negedge clk);
    checkOutput("single_rd", 64'(bus.rd_fifo), 64'b0100);
    checkOutput("single_rv_read", 64'(bus.req_v), 64'd0);
    @(negedge clk);
    checkOutput("single_rd_wait", 64'(bus.rd_fifo), 64'd0);
    checkOutput("single_rv_wait", 64'(bus.req_v), 64'd0);
    @(negedge clk);
    checkOutput("single_rv", 64'(bus.req_v), 64'd1);
    checkOutput("single_req_o", 64'(bus.req_o), 64'hA5);
    checkOutput("single_req_ch", 64'(bus.req_ch), 64'd2);
    @(negedge clk);
    checkOutput("single_idle", 64'(bus.busy), 64'd0);
    gotCh.delete();
    gotDat.delete();
    applyStimulus(1, 1, DW'($urandom));
    applyStimulus(3, 1, DW'($urandom));
    buildExpected(3, '0);
    collectAndCompare("ptr_after_single", 50);

    $display("[TB] fairness");
    resetDut();
    bus.req_rdy = 1'b1;
    for (int c = 0; c < NCH; c++) applyStimulus(c, 8, DW'($urandom));
    buildExpected(0, '0);
    collectAndCompare("fair", 400);

    $display("[TB] early release");
    resetDut();
    applyStimulus(1, 2, DW'($urandom));
    applyStimulus(3, 5, DW'($urandom));
    buildExpected(0, '0);
    collectAndCompare("early", 200);

    $display("[TB] randomized occupancy and ready");
    for (int r = 0; r < 4; r++) begin
      resetDut();
      for (int c = 0; c < NCH; c++) applyStimulus(c, int'($urandom_range(0, 6)), DW'($urandom));
      buildExpected(0, '0);
      rdyRandom = 1'b1;
      collectAndCompare("rand", 1000);
      rdyRandom   = 1'b0;
      bus.req_rdy = 1'b1;
      checkOutput("rand_err", 64'(bus.err), 64'd0);
    end

    $display("[TB] backpressure");
    resetDut();
    bus.req_rdy = 1'b0;
    v = DW'($urandom);
    applyStimulus(0, 1, v);
    applyStimulus(1, 1, DW'($urandom));
    for (int i = 0; i < 10 && !bus.req_v; i++) @(negedge clk);
    checkOutput("bp_valid", 64'(bus.req_v), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_v", 64'(bus.req_v), 64'd1);
      checkOutput("bp_hold_o", 64'(bus.req_o), 64'(v));
      checkOutput("bp_hold_ch", 64'(bus.req_ch), 64'd0);
      checkOutput("bp_no_read", 64'(bus.rd_fifo), 64'd0);
    end
    bus.req_rdy = 1'b1;
    @(negedge clk);
    checkOutput("bp_accept_cnt", 64'(gotCh.size()), 64'd1);
    checkOutput("bp_accept_dat", (gotDat.size() > 0) ? 64'(gotDat[0]) : 64'hDEAD, 64'(v));
    checkOutput("bp_released", 64'(bus.req_v), 64'd0);
    repeat (8) @(negedge clk);
    gotCh.delete();
    gotDat.delete();

    $display("[TB] reset mid-burst");
    resetDut();
    bus.req_rdy = 1'b1;
    applyStimulus(0, 3, DW'($urandom));
    for (int i = 0; i < 10 && !bus.rd_fifo[0]; i++) @(negedge clk);
    checkOutput("mid_read_seen", 64'(bus.rd_fifo), 64'b0001);
    @(posedge clk);
    #2;
    checkOutput("mid_wait_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_rd_fifo", 64'(bus.rd_fifo), 64'd0);
    checkOutput("mid_rst_req_v", 64'(bus.req_v), 64'd0);
    checkOutput("mid_rst_req_o", 64'(bus.req_o), 64'd0);
    checkOutput("mid_rst_req_ch", 64'(bus.req_ch), 64'd0);
    checkOutput("mid_rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("mid_rst_err", 64'(bus.err), 64'd0);
    @(negedge clk);
    bus.rd_rst_busy[0] = 1'b1;
    applyStimulus(3, 1, DW'($urandom));
    applyStimulus(2, 1, DW'($urandom));
    @(negedge clk);
    gotCh.delete();
    gotDat.delete();
    rst_n = 1'b1;
    buildExpected(0, 4'b0001);
    collectAndCompare("masked", 100);
    bus.rd_rst_busy[0] = 1'b0;
    buildExpected(0, '0);
    collectAndCompare("unmasked", 100);

    $display("[TB] missing data_valid");
    resetDut();
    bus.req_rdy = 1'b1;
    dropValid   = 1'b1;
    applyStimulus(1, 1, DW'($urandom));
    repeat (6) @(negedge clk);
    dropValid = 1'b0;
    checkOutput("miss_err", 64'(bus.err), 64'd1);
    checkOutput("miss_idle", 64'(bus.busy), 64'd0);
    checkOutput("miss_no_req", 64'(gotCh.size()), 64'd0);
    applyStimulus(0, 1, DW'($urandom));
    applyStimulus(2, 1, DW'($urandom));
    buildExpected(2, '0);
    collectAndCompare("miss_ptr", 100);
    checkOutput("miss_err_sticky", 64'(bus.err), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
